// File: rtl/set_bit_enumerator.sv
// set_bit_enumerator: accepts one word and emits the position of every set
// bit, lowest first, one position per output beat. A zero word yields a
// single beat carrying EMPTY_LOC with out_empty set.
module set_bit_enumerator #(
  parameter int DATA_W    = 8,
  parameter int LOC_W     = 6,
  parameter int EMPTY_LOC = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOC_W-1:0]  out_loc,
  output logic              out_last,
  output logic              out_empty,
  output logic [15:0]       word_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rem;
  logic              accept;
  logic              beat_done;
  logic              word_done;

  // Priority encode from bit 0 upward; the lowest set bit wins because it
  // is visited last. A zero word returns 0 (callers handle that case).
  function automatic logic [LOC_W-1:0] tzc(input logic [DATA_W-1:0] x);
    logic [LOC_W-1:0] r;
    r = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (x[i]) r = LOC_W'(i);
    end
    return r;
  endfunction

  // x with its lowest set bit cleared.
  function automatic logic [DATA_W-1:0] clear_lowest(input logic [DATA_W-1:0] x);
    return x & (x - DATA_W'(1));
  endfunction

  function automatic int popcount(input logic [DATA_W-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < DATA_W; i++) begin
      if (x[i]) n++;
    end
    return n;
  endfunction

  // Handshake decode; in_ready opens on the final beat so words chain
  // back-to-back without an idle cycle.
  always_comb begin
    beat_done = out_valid & out_ready;
    word_done = beat_done & out_last;
    in_ready  = rst_n & ((state == IDLE) | word_done);
    accept    = in_valid & in_ready;
  end

  // Enumeration FSM with registered beat outputs and completed-word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      out_valid  <= 1'b0;
      out_loc    <= '0;
      out_last   <= 1'b0;
      out_empty  <= 1'b0;
      word_count <= '0;
    end else begin
      if (word_done) word_count <= word_count + 16'd1;

      if (accept) begin
        rem       <= clear_lowest(in_data);
        out_last  <= (popcount(in_data) <= 1);
        out_valid <= 1'b1;
        state     <= EMIT;
        if (in_data == '0) begin
          out_loc   <= LOC_W'(EMPTY_LOC);
          out_empty <= 1'b1;
        end else begin
          out_loc   <= tzc(in_data);
          out_empty <= 1'b0;
        end
      end else if (beat_done) begin
        if (!out_last) begin
          out_loc  <= tzc(rem);
          rem      <= clear_lowest(rem);
          out_last <= (popcount(rem) == 1);
        end else begin
          out_valid <= 1'b0;
          state     <= IDLE;
          out_last  <= 1'b0;
          out_empty <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Scoreboard bench for set_bit_enumerator: the driver pushes the beats a
// word should produce, a negedge monitor pops and compares every handshake.
module tb_set_bit_enumerator;

  localparam int DATA_W = 8;
  localparam int LOC_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LOC_W-1:0]  out_loc;
  logic              out_last;
  logic              out_empty;
  logic [15:0]       word_count;

  typedef struct packed {
    logic [LOC_W-1:0] loc;
    logic             last;
    logic             empty;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] model_wc;
  int          tests = 0;
  int          fails = 0;
  int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic        rnd_ready = 1'b1;
  logic        rec = 1'b0;
  logic        v_hist[$];
  logic        r_hist[$];

  set_bit_enumerator #(.DATA_W(DATA_W), .LOC_W(LOC_W), .EMPTY_LOC(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_loc(out_loc), .out_last(out_last), .out_empty(out_empty),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom % 3) != 0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: list every set bit position lowest first; zero word -> 32.
  task automatic push_model(input logic [DATA_W-1:0] d);
    int pos[$];
    beat_t b;
    for (int i = 0; i < DATA_W; i++) if (d[i]) pos.push_back(i);
    if (pos.size() == 0) begin
      b.loc = 6'd32; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        b.loc = LOC_W'(pos[k]); b.last = (k == pos.size() - 1); b.empty = 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the following edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_wc = 16'd0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", int'({out_loc, out_last, out_empty}), int'(e));
        if (e.last) model_wc = model_wc + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (rec) begin
      v_hist.push_back(out_valid);
      r_hist.push_back(in_ready);
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        push_model(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_wc = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_loc", int'(out_loc), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_empty", int'(out_empty), 0);
    check("rst_word_count", int'(word_count), 0);
    check("idle_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Zero word then directed single words
    send(8'h00);
    drain();
    check("zero_word_count", int'(word_count), 1);
    check("idle_after_zero", int'(out_valid), 0);
    send(8'h03); drain();
    send(8'h04); drain();
    send(8'h80); drain();
    check("directed_count", int'(word_count), 4);

    // Back-to-back 8'hFF, 8'h81
    do_reset();
    rec = 1'b1;
    send(8'hFF);
    send(8'h81);
    repeat (3) @(posedge clk);
    #1;
    rec = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      check($sformatf("b2b_valid_c%0d", c), int'(v_hist[c]), (c >= 1 && c <= 10) ? 1 : 0);
      if (c <= 10)
        check($sformatf("b2b_ready_c%0d", c), int'(r_hist[c]), (c == 0 || c == 8 || c == 10) ? 1 : 0);
    end
    drain();
    check("b2b_word_count", int'(word_count), 2);

    // Backpressure on 8'b0010_1000
    ready_mode = 0;
    send(8'h28);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_loc_hold", int'(out_loc), 3);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    ready_mode = 1;
    @(negedge clk);
    check("bp_in_ready_first", int'(in_ready), 0);
    drain();
    check("bp_word_count", int'(word_count), 3);

    // Reset mid-word
    send(8'hF0);
    @(negedge clk);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_loc", int'(out_loc), 0);
    check("mid_rst_last", int'(out_last), 0);
    check("mid_rst_empty", int'(out_empty), 0);
    check("mid_rst_count", int'(word_count), 0);
    @(posedge clk); #1;
    send(8'h02);
    drain();
    check("post_rst_count", int'(word_count), 1);

    // Randomized words with random backpressure and input gaps
    ready_mode = 2;
    for (int w = 0; w < 300; w++) begin
      logic [DATA_W-1:0] d;
      d = (($urandom % 8) == 0) ? '0 : DATA_W'($urandom);
      if (($urandom % 4) == 0) begin
        @(posedge clk); #1;
      end
      send(d);
    end
    ready_mode = 1;
    drain();
    check("random_count", int'(word_count), int'(model_wc));

    // Wrap of word_count
    do_reset();
    for (int w = 0; w < 65535; w++) send(8'h00);
    drain();
    check("pre_wrap_count", int'(word_count), 65535);
    send(8'h00);
    drain();
    check("wrap_count", int'(word_count), 0);
    check("wrap_model", int'(word_count), int'(model_wc));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/set_bit_enumerator.md
# set_bit_enumerator

Multi-cycle stage that accepts one DATA_W-bit word and emits the position of every set bit, lowest first, one position per output beat. Each position is the trailing-zero count of the remaining word, after which that bit is cleared. It sits directly downstream of the data source and feeds the location consumer. An all-zero word produces a single beat carrying the invalid location 32, matching the location-finder convention used elsewhere in the design.

## Interface
- DATA_W, 8: input word width; 2..32.
- LOC_W, 6: location width; must hold EMPTY_LOC.
- EMPTY_LOC, 32: location reported for an all-zero word.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA_W  word to enumerate.
- out_valid  output  1  out_loc, out_last and out_empty are valid.
- out_ready  input  1  consumer takes the beat this cycle.
- out_loc  output  LOC_W  bit position of the current lowest set bit, or EMPTY_LOC.
- out_last  output  1  final beat of the current word.
- out_empty  output  1  word was zero; beat carries EMPTY_LOC.
- word_count  output  16  words fully emitted since reset; wraps at 65535 to 0.

## Operation
- State machine with two states: IDLE and EMIT. A remaining-word register `rem` holds DATA_W bits.
- Accept: in_valid & in_ready. On accept:
  - rem <= in_data with its lowest set bit cleared.
  - out_loc <= trailing-zero count of in_data.
  - out_last <= (popcount(in_data) ≤ 1).
  - out_empty <= (in_data == 0); if set, out_loc <= EMPTY_LOC.
  - out_valid <= 1; state <= EMIT.
- Output handshake: out_valid & out_ready.
  - If out_last is 0: out_loc <= trailing-zero count of rem, rem <= rem with its lowest set bit cleared, out_last <= (popcount(rem) == 1).
  - If out_last is 1: word_count increments. If an accept occurs in the same cycle, the registers load the new word. Otherwise out_valid <= 0, state <= IDLE, and out_last and out_empty clear.
- in_ready = rst_n & (state==IDLE | (out_valid & out_ready & out_last)). The block is combinational in ready only; there is no in_ready→in_valid path.
- Stall: while out_valid & !out_ready, out_loc, out_last, out_empty and rem hold.
- Trailing-zero count is a priority encode from bit 0 upward. The result is zero-extended to LOC_W.
- in_data is sampled only on accept. Later changes to in_data have no effect.

## Timing
- Reset (rst_n low at a clk edge): state=IDLE, rem=0, out_valid=0, out_loc=0, out_last=0, out_empty=0, word_count=0. in_ready is 0 while rst_n is low.
- Latency: a word accepted at edge t gives its first beat with out_valid high after edge t.
- Throughput: a word with N set bits (N≥1) occupies N output cycles with out_ready held high. A zero word occupies 1 cycle.
- Back-to-back: a new word is accepted on the same edge as the previous word's last beat, so there are no bubbles.
- Reset mid-word: the in-flight word is discarded, no further beats are emitted, and word_count does not count the discarded word.
- Reset wins over a simultaneous accept or output handshake.
- word_count increments on the last-beat handshake of each word, including zero words.

## Test plan
- Single words with out_ready=1: 8'b0000_0011 → beats loc=0 (last=0), then loc=1 (last=1). 8'b0000_0100 → one beat, loc=2, last=1. 8'b1000_0000 → one beat, loc=7, last=1.
- Zero word: in_data=8'h00 → one beat, loc=32, empty=1, last=1. word_count goes 0→1.
- Back-to-back throughput: 8'hFF, then 8'h81, with in_valid and out_ready held high → locs 0..7, then 0 and 7. Exactly 10 consecutive out_valid cycles. in_ready is high only on the two last beats and in the initial IDLE cycle. word_count=2.
- Backpressure: 8'b0010_1000 with out_ready low for 3 cycles after the first out_valid → loc=3 holds stable for those cycles. Then loc=3, loc=5 (last). in_ready stays low throughout.
- Reset mid-word: accept 8'hF0, take the loc=4 beat, then pull rst_n low for one edge. All outputs read reset values and word_count=0. A following word 8'h02 yields loc=1, last=1.
- Wrap: preset by driving 65536 zero words (or via force) → word_count returns to 0 after the 65536th word.
